// File: rtl/if_id_stage.sv
// IF/ID pipeline register with hazard stall, flush bubble and issue counters.
// Holds one fetched instruction in decode and issues it to EX one cycle after
// fetch unless the forwarding unit flags a hazard or a redirect flushes it.
module if_id_stage #(
  parameter int              WORD_SIZE = 16,
  parameter logic [WORD_SIZE-1:0] NOP_INST = 16'hC000,
  parameter int              MAX_STALL = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 if_valid,
  input  logic [WORD_SIZE-1:0] if_inst,
  input  logic [WORD_SIZE-1:0] if_pc,
  input  logic                 data_hazard,
  input  logic                 flush,
  output logic [WORD_SIZE-1:0] id_inst,
  output logic [WORD_SIZE-1:0] id_pc,
  output logic                 id_valid,
  output logic [WORD_SIZE-1:0] ex_inst,
  output logic                 pc_write,
  output logic [WORD_SIZE-1:0] num_inst,
  output logic [WORD_SIZE-1:0] stall_count,
  output logic                 stall_error
);

  typedef enum logic [1:0] {RUN, STALL, FLUSH} state_t;

  localparam logic [WORD_SIZE-1:0] MAX_STALL_W = WORD_SIZE'(MAX_STALL);

  state_t               state, state_nxt;
  logic                 do_flush;   // redirect: bubble the register
  logic                 do_stall;   // hazard on a real instruction: hold
  logic                 do_load;    // capture the fetch-side word
  logic                 do_drop;    // first cycle after flush: discard fetch
  logic                 issue;      // id_inst goes to EX this cycle
  logic [WORD_SIZE-1:0] cons_cnt;   // consecutive stall cycles, saturating

  // Next-state and per-cycle control; flush beats hazard beats a normal load
  always_comb begin
    state_nxt = state;
    do_flush  = 1'b0;
    do_stall  = 1'b0;
    do_load   = 1'b0;
    do_drop   = 1'b0;
    issue     = 1'b0;
    if (flush) begin
      do_flush  = 1'b1;
      state_nxt = FLUSH;
    end else begin
      case (state)
        FLUSH: begin
          // Fetch word this cycle is wrong-path; keep the bubble
          do_drop   = 1'b1;
          state_nxt = RUN;
        end
        default: begin
          // RUN and STALL share the same decision; only the hazard matters
          if (data_hazard && id_valid) begin
            do_stall  = 1'b1;
            state_nxt = STALL;
          end else begin
            issue     = id_valid;
            do_load   = 1'b1;
            state_nxt = RUN;
          end
        end
      endcase
    end
  end

  assign ex_inst  = issue ? id_inst : NOP_INST;
  assign pc_write = ~do_stall;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= RUN;
    else       state <= state_nxt;
  end

  // Decode register: load, hold on stall, bubble on flush or drop
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      id_inst  <= NOP_INST;
      id_pc    <= '0;
      id_valid <= 1'b0;
    end else if (do_flush || do_drop) begin
      id_inst  <= NOP_INST;
      id_valid <= 1'b0;
    end else if (do_load) begin
      id_inst  <= if_inst;
      id_pc    <= if_pc;
      id_valid <= if_valid;
    end
  end

  // Issued-instruction and stall-cycle counters, both wrap naturally
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      num_inst    <= '0;
      stall_count <= '0;
    end else begin
      if (issue)    num_inst    <= num_inst + 1'b1;
      if (do_stall) stall_count <= stall_count + 1'b1;
    end
  end

  // Consecutive-stall watchdog; error is sticky, the stall itself continues
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cons_cnt    <= '0;
      stall_error <= 1'b0;
    end else if (do_stall) begin
      if (cons_cnt >= MAX_STALL_W) stall_error <= 1'b1;
      if (cons_cnt <= MAX_STALL_W) cons_cnt <= cons_cnt + 1'b1;
    end else begin
      cons_cnt <= '0;
    end
  end

endmodule

// File: tb/tb_if_id_stage.sv
// Directed bench for if_id_stage: issue latency, hazard stall, flush drop,
// stall watchdog, async reset mid-stall and num_inst wrap.
module tb_if_id_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_valid;
  logic [15:0] if_inst;
  logic [15:0] if_pc;
  logic        data_hazard;
  logic        flush;
  logic [15:0] id_inst;
  logic [15:0] id_pc;
  logic        id_valid;
  logic [15:0] ex_inst;
  logic        pc_write;
  logic [15:0] num_inst;
  logic [15:0] stall_count;
  logic        stall_error;

  int total  = 0;
  int passed = 0;

  localparam logic [15:0] NOP = 16'hC000;

  if_id_stage #(.WORD_SIZE(16), .NOP_INST(16'hC000), .MAX_STALL(3)) dut (
    .clk(clk), .reset(reset), .if_valid(if_valid), .if_inst(if_inst),
    .if_pc(if_pc), .data_hazard(data_hazard), .flush(flush),
    .id_inst(id_inst), .id_pc(id_pc), .id_valid(id_valid), .ex_inst(ex_inst),
    .pc_write(pc_write), .num_inst(num_inst), .stall_count(stall_count),
    .stall_error(stall_error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // Advance one rising edge, then settle away from it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [15:0] inst, input logic [15:0] pc,
                       input logic hz, input logic fl);
    if_valid = v; if_inst = inst; if_pc = pc; data_hazard = hz; flush = fl;
  endtask

  initial begin
    reset = 1'b1;
    drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
    #12;
    // Reset state
    chk("rst_id_inst", id_inst, NOP);
    chk("rst_id_pc", id_pc, 16'h0);
    chk("rst_id_valid", {15'h0, id_valid}, 16'h0);
    chk("rst_num_inst", num_inst, 16'h0);
    chk("rst_stall_count", stall_count, 16'h0);
    chk("rst_stall_error", {15'h0, stall_error}, 16'h0);
    chk("rst_pc_write", {15'h0, pc_write}, 16'h1);
    chk("rst_ex_inst", ex_inst, NOP);
    reset = 1'b0;
    tick();

    // Scenario 1: three back-to-back instructions, one-cycle latency
    drive(1'b1, 16'h1111, 16'd0, 1'b0, 1'b0);
    tick();
    chk("s1_id_inst0", id_inst, 16'h1111);
    chk("s1_ex_inst0", ex_inst, 16'h1111);
    drive(1'b1, 16'h2222, 16'd1, 1'b0, 1'b0);
    #1 chk("s1_id_pc0", id_pc, 16'd0);
    tick();
    chk("s1_ex_inst1", ex_inst, 16'h2222);
    chk("s1_id_pc1", id_pc, 16'd1);
    drive(1'b1, 16'h3333, 16'd2, 1'b0, 1'b0);
    tick();
    chk("s1_ex_inst2", ex_inst, 16'h3333);
    drive(1'b0, 16'h0, 16'd0, 1'b0, 1'b0);
    tick();
    chk("s1_num_inst", num_inst, 16'd3);
    chk("s1_ex_idle", ex_inst, NOP);

    // Scenario 2: two-cycle hazard stall
    drive(1'b1, 16'h4444, 16'd3, 1'b0, 1'b0);
    tick();
    drive(1'b1, 16'h5555, 16'd4, 1'b1, 1'b0);
    #1;
    chk("s2_pc_write_a", {15'h0, pc_write}, 16'h0);
    chk("s2_ex_nop_a", ex_inst, NOP);
    tick();
    chk("s2_hold_a", id_inst, 16'h4444);
    chk("s2_pc_write_b", {15'h0, pc_write}, 16'h0);
    chk("s2_ex_nop_b", ex_inst, NOP);
    tick();
    chk("s2_hold_b", id_inst, 16'h4444);
    chk("s2_stall_count", stall_count, 16'd2);
    data_hazard = 1'b0;
    #1;
    chk("s2_release_ex", ex_inst, 16'h4444);
    chk("s2_release_pcw", {15'h0, pc_write}, 16'h1);
    tick();
    chk("s2_num_inst", num_inst, 16'd4);
    chk("s2_next_loaded", id_inst, 16'h5555);

    // Scenario 3: flush with hazard; flush wins and next fetch is dropped
    drive(1'b1, 16'h6666, 16'd5, 1'b1, 1'b1);
    #1;
    chk("s3_ex_nop", ex_inst, NOP);
    chk("s3_pcw", {15'h0, pc_write}, 16'h1);
    tick();
    chk("s3_id_valid", {15'h0, id_valid}, 16'h0);
    chk("s3_id_inst", id_inst, NOP);
    chk("s3_stall_count", stall_count, 16'd2);
    drive(1'b1, 16'h7777, 16'd6, 1'b0, 1'b0);
    #1 chk("s3_flush_pcw", {15'h0, pc_write}, 16'h1);
    tick();
    chk("s3_drop_valid", {15'h0, id_valid}, 16'h0);
    chk("s3_drop_inst", id_inst, NOP);
    drive(1'b1, 16'h8888, 16'd7, 1'b0, 1'b0);
    tick();
    chk("s3_reload", id_inst, 16'h8888);
    chk("s3_num_inst", num_inst, 16'd4);

    // Scenario 4: four stall cycles against MAX_STALL=3
    drive(1'b0, 16'h0, 16'd0, 1'b1, 1'b0);
    tick(); tick(); tick();
    chk("s4_no_err_3", {15'h0, stall_error}, 16'h0);
    tick();
    chk("s4_err_4", {15'h0, stall_error}, 16'h1);
    chk("s4_still_held", id_inst, 16'h8888);
    chk("s4_stall_count", stall_count, 16'd6);
    data_hazard = 1'b0;
    tick();
    chk("s4_err_sticky", {15'h0, stall_error}, 16'h1);
    chk("s4_num_inst", num_inst, 16'd5);

    // Scenario 6: asynchronous reset in the middle of a stall
    drive(1'b1, 16'h9999, 16'd8, 1'b0, 1'b0);
    tick();
    drive(1'b0, 16'h0, 16'd0, 1'b1, 1'b0);
    tick();
    #2 reset = 1'b1;
    #1;
    chk("s6_id_inst", id_inst, NOP);
    chk("s6_id_valid", {15'h0, id_valid}, 16'h0);
    chk("s6_num_inst", num_inst, 16'h0);
    chk("s6_stall_count", stall_count, 16'h0);
    chk("s6_stall_error", {15'h0, stall_error}, 16'h0);
    chk("s6_pcw", {15'h0, pc_write}, 16'h1);
    tick();
    reset = 1'b0;
    drive(1'b1, 16'hAAAA, 16'd9, 1'b0, 1'b0);
    tick();
    chk("s6_post_load", id_inst, 16'hAAAA);
    chk("s6_post_ex", ex_inst, 16'hAAAA);
    drive(1'b0, 16'h0, 16'd0, 1'b0, 1'b0);
    tick();
    chk("s6_post_num", num_inst, 16'd1);

    // Scenario 5: drive num_inst up to all-ones, then one more issue wraps it
    drive(1'b1, 16'h0001, 16'd0, 1'b0, 1'b0);
    tick();
    for (int i = 0; i < 65534; i++) begin
      if_inst = 16'(i);
      tick();
    end
    chk("s5_all_ones", num_inst, 16'hFFFF);
    tick();
    chk("s5_wrap", num_inst, 16'h0000);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/if_id_stage.md
IF_ID_STAGE -- requirements
Module: if_id_stage

Interface
REQ-001 Parameter WORD_SIZE, default 16, width of instruction and PC words.
REQ-002 Parameter NOP_INST, default 16'hC000, bubble encoding driven downstream when no valid instruction is issued.
REQ-003 Parameter MAX_STALL, default 3, maximum legal consecutive hazard-stall cycles.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 if_valid  input  1  fetch stage presents a valid instruction this cycle.
REQ-007 if_inst  input  WORD_SIZE  fetched instruction.
REQ-008 if_pc  input  WORD_SIZE  PC of the fetched instruction.
REQ-009 data_hazard  input  1  hazard flag from the forwarding unit, evaluated against id_inst.
REQ-010 flush  input  1  control-flow redirect; younger fetched instructions are wrong-path.
REQ-011 id_inst  output  WORD_SIZE  instruction held in decode.
REQ-012 id_pc  output  WORD_SIZE  PC held in decode.
REQ-013 id_valid  output  1  id_inst is a real instruction.
REQ-014 ex_inst  output  WORD_SIZE  instruction issued to EX this cycle: id_inst, or NOP_INST when not issuing.
REQ-015 pc_write  output  1  fetch may advance the PC.
REQ-016 num_inst  output  WORD_SIZE  count of real instructions issued to EX.
REQ-017 stall_count  output  WORD_SIZE  count of hazard-stall cycles.
REQ-018 stall_error  output  1  sticky flag: stall exceeded MAX_STALL.

Function
REQ-019 The state machine SHALL have three states, RUN, STALL and FLUSH, and SHALL reset to RUN.
REQ-020 Flush SHALL take priority over hazard, and hazard SHALL take priority over a normal load.
REQ-021 In RUN with flush=0 and (data_hazard=0 or id_valid=0): issue SHALL be id_valid, and the register SHALL load if_inst/if_pc with id_valid<=if_valid, pc_write=1.
REQ-022 In RUN or STALL with flush=0, data_hazard=1 and id_valid=1: the register SHALL hold, pc_write=0, ex_inst=NOP_INST, state<=STALL, and stall_count SHALL increment.
REQ-023 In STALL with data_hazard=0 and flush=0: the stage SHALL issue id_inst, load the new input as in REQ-021, and set state<=RUN.
REQ-024 When flush=1 in any state: id_inst<=NOP_INST, id_valid<=0, ex_inst=NOP_INST, pc_write=1, state<=FLUSH.
REQ-025 In FLUSH: if_valid/if_inst SHALL be discarded (one-cycle wrong-path drop), the register SHALL stay NOP/invalid, pc_write=1, and state<=RUN unless flush=1 again.
REQ-026 ex_inst SHALL be combinational: id_inst when issuing, else NOP_INST.
REQ-027 num_inst SHALL increment by 1 on each cycle in which ex_inst=id_inst and id_valid=1.
REQ-028 num_inst and stall_count SHALL wrap from all-ones to 0.
REQ-029 A consecutive-stall counter SHALL clear on any non-stall cycle.
REQ-030 If the consecutive-stall counter would exceed MAX_STALL, stall_error SHALL set and stay set until reset, and the stall SHALL continue.
REQ-031 Latency SHALL be one cycle: an instruction sampled at edge N appears on id_inst after edge N and issues in that cycle if no hazard is present.

Reset
REQ-032 While reset=1, asynchronously: id_inst=NOP_INST, id_pc=0, id_valid=0, state=RUN, num_inst=0, stall_count=0, stall_error=0, and the consecutive-stall counter=0.
REQ-033 Reset asserted mid-STALL or mid-FLUSH SHALL return to RUN with no further issue and no counter update on that edge.
REQ-034 The first cycle after reset deasserts SHALL behave as RUN with an empty register (pc_write=1).

Verification
REQ-035 Scenario 1: three consecutive valid instructions at PC 0,1,2 with no hazard -> each issues one cycle after fetch; num_inst=3.
REQ-036 Scenario 2: data_hazard=1 for 2 cycles with id_valid=1 -> id_inst held, pc_write=0 for 2 cycles, ex_inst=NOP_INST for 2 cycles, stall_count=2, then issue and return to RUN.
REQ-037 Scenario 3: flush and data_hazard both high -> flush wins; id_valid=0, next if_inst dropped, num_inst unchanged.
REQ-038 Scenario 4: data_hazard held for 4 cycles with MAX_STALL=3 -> stall_error=1 on the 4th stall edge and stays 1 after the hazard clears.
REQ-039 Scenario 5: preload num_inst to 16'hFFFF, then issue one instruction -> num_inst=16'h0000.
REQ-040 Scenario 6: assert reset asynchronously mid-STALL -> outputs immediately take the reset values of REQ-032; first post-reset fetch issues normally.
